// File: rtl/context_sequencer_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : context_sequencer_fsm
//  Description : Context-level sequencer driving the context switch controller,
//                counting swapped-out contexts and applying drain back-pressure.
//  Revision    : 1.0
// ============================================================================
module context_sequencer_fsm #(
    parameter int CTX_W    = 16,
    parameter int PEND_MAX = 2
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_start,
    input  logic [CTX_W-1:0] i_ncontexts,
    input  logic             i_abort,
    input  logic             i_flush,
    input  logic             i_cdone,
    input  logic             i_cswitch_done,
    input  logic             i_out_ready,
    output logic             o_clear,
    output logic             o_cswitch_en,
    output logic             o_cswitch_force,
    output logic             o_stall_req,
    output logic             o_ctx_swapped,
    output logic             o_busy,
    output logic             o_done,
    output logic [CTX_W-1:0] o_ctx_cnt,
    output logic             o_err
);

    localparam int                PEND_W     = $clog2(PEND_MAX + 1);
    localparam logic [PEND_W-1:0] C_PEND_MAX = PEND_W'(PEND_MAX);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_RUN    = 3'd2,
        S_SWITCH = 3'd3,
        S_FORCE  = 3'd4,
        S_DONE   = 3'd5,
        S_ABORT  = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CTX_W-1:0]  r_ncx;
    logic [CTX_W-1:0]  w_ncx_nxt;
    logic [CTX_W-1:0]  r_ctx_cnt;
    logic [CTX_W-1:0]  w_ctx_cnt_nxt;
    logic [PEND_W-1:0] r_pend;
    logic [PEND_W-1:0] w_pend_nxt;
    logic              r_flush_pend;
    logic              w_flush_pend_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              r_force_first;
    logic              w_force_first_nxt;

    logic              w_active;
    logic              w_pend_inc;
    logic              w_pend_dec;
    logic              w_last;

    assign w_active   = (r_state == S_RUN) || (r_state == S_SWITCH) || (r_state == S_FORCE);
    assign w_pend_inc = i_cdone && w_active;
    // Only a cdone-initiated switch retires a pending context.
    assign w_pend_dec = (r_state == S_SWITCH) && i_cswitch_done && (r_pend != '0);
    assign w_last     = (({1'b0, r_ctx_cnt} + {{CTX_W{1'b0}}, 1'b1}) == {1'b0, r_ncx});

    assign o_busy      = (r_state != S_IDLE);
    assign o_ctx_cnt   = r_ctx_cnt;
    assign o_err       = r_err;
    assign o_stall_req = w_active &&
                         (((r_pend != '0) && !i_out_ready) || (r_pend == C_PEND_MAX));

    always_comb begin
        w_state_nxt       = r_state;
        w_ncx_nxt         = r_ncx;
        w_ctx_cnt_nxt     = r_ctx_cnt;
        w_pend_nxt        = r_pend;
        w_flush_pend_nxt  = r_flush_pend;
        w_err_nxt         = r_err;
        w_force_first_nxt = 1'b0;
        o_clear           = (r_state == S_CLEAR) || (r_state == S_ABORT);
        o_done            = (r_state == S_DONE);
        o_cswitch_en      = (r_state == S_SWITCH) || (r_state == S_FORCE);
        o_cswitch_force   = (r_state == S_FORCE) && r_force_first;
        o_ctx_swapped     = 1'b0;

        if (w_pend_inc && !w_pend_dec) begin
            if (r_pend == C_PEND_MAX) begin
                w_err_nxt = 1'b1;
            end else begin
                w_pend_nxt = r_pend + 1'b1;
            end
        end else if (w_pend_dec && !w_pend_inc) begin
            w_pend_nxt = r_pend - 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_ncontexts != '0) ? S_CLEAR : S_DONE;
                end
            end
            S_CLEAR: begin
                w_ncx_nxt        = i_ncontexts;
                w_ctx_cnt_nxt    = '0;
                w_pend_nxt       = '0;
                w_flush_pend_nxt = 1'b0;
                w_err_nxt        = 1'b0;
                w_state_nxt      = S_RUN;
            end
            S_RUN: begin
                if (i_flush) begin
                    w_flush_pend_nxt = 1'b1;
                end
                if (((r_pend != '0) || i_cdone) && i_out_ready) begin
                    w_state_nxt = S_SWITCH;
                end else if ((r_flush_pend || i_flush) && (r_pend == '0) && i_out_ready) begin
                    w_state_nxt       = S_FORCE;
                    w_force_first_nxt = 1'b1;
                end
            end
            S_SWITCH, S_FORCE: begin
                if (i_cswitch_done) begin
                    o_ctx_swapped = 1'b1;
                    w_ctx_cnt_nxt = r_ctx_cnt + 1'b1;
                    if (r_state == S_FORCE) begin
                        w_flush_pend_nxt = 1'b0;
                    end
                    // Exit decisions look at pend after this cycle's update.
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                        if (w_pend_nxt != '0) begin
                            w_err_nxt = 1'b1;
                        end
                    end else if ((w_pend_nxt != '0) && i_out_ready) begin
                        w_state_nxt = S_SWITCH;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ABORT: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // Abort wins over every transition and freezes the bookkeeping for that cycle.
        if (i_abort && (r_state != S_IDLE)) begin
            w_state_nxt       = S_ABORT;
            w_ncx_nxt         = r_ncx;
            w_ctx_cnt_nxt     = r_ctx_cnt;
            w_pend_nxt        = r_pend;
            w_flush_pend_nxt  = r_flush_pend;
            w_err_nxt         = r_err;
            w_force_first_nxt = 1'b0;
            o_ctx_swapped     = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state       <= S_IDLE;
            r_ncx         <= '0;
            r_ctx_cnt     <= '0;
            r_pend        <= '0;
            r_flush_pend  <= 1'b0;
            r_err         <= 1'b0;
            r_force_first <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ncx         <= w_ncx_nxt;
            r_ctx_cnt     <= w_ctx_cnt_nxt;
            r_pend        <= w_pend_nxt;
            r_flush_pend  <= w_flush_pend_nxt;
            r_err         <= w_err_nxt;
            r_force_first <= w_force_first_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_context_sequencer_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_context_sequencer_fsm
//  Description : Self-checking bench for context_sequencer_fsm against a
//                behavioural model, with directed scenarios and random traffic.
//  Revision    : 1.0
// ============================================================================
module tb_context_sequencer_fsm;
    localparam int CTX_W    = 16;
    localparam int PEND_MAX = 2;

    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_RUN   = 2;
    localparam int P_SW    = 3;
    localparam int P_FORCE = 4;
    localparam int P_DONE  = 5;
    localparam int P_ABORT = 6;

    logic             i_clk = 1'b0;
    logic             i_rstn = 1'b0;
    logic             i_start = 1'b0;
    logic [CTX_W-1:0] i_ncontexts = '0;
    logic             i_abort = 1'b0;
    logic             i_flush = 1'b0;
    logic             i_cdone = 1'b0;
    logic             i_cswitch_done = 1'b0;
    logic             i_out_ready = 1'b0;
    logic             o_clear, o_cswitch_en, o_cswitch_force, o_stall_req;
    logic             o_ctx_swapped, o_busy, o_done, o_err;
    logic [CTX_W-1:0] o_ctx_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model of the sequencer, one entry per clock.
    int m_ph, m_ncx, m_cnt, m_pend;
    bit m_flush, m_err, m_first;
    int ev_clear, ev_done, ev_swapped, ev_stall;

    always #5 i_clk = ~i_clk;

    context_sequencer_fsm #(.CTX_W(CTX_W), .PEND_MAX(PEND_MAX)) dut (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_start        (i_start),
        .i_ncontexts    (i_ncontexts),
        .i_abort        (i_abort),
        .i_flush        (i_flush),
        .i_cdone        (i_cdone),
        .i_cswitch_done (i_cswitch_done),
        .i_out_ready    (i_out_ready),
        .o_clear        (o_clear),
        .o_cswitch_en   (o_cswitch_en),
        .o_cswitch_force(o_cswitch_force),
        .o_stall_req    (o_stall_req),
        .o_ctx_swapped  (o_ctx_swapped),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_ctx_cnt      (o_ctx_cnt),
        .o_err          (o_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = P_IDLE; m_ncx = 0; m_cnt = 0; m_pend = 0;
        m_flush = 0; m_err = 0; m_first = 0;
    endtask

    function automatic bit m_active();
        return (m_ph == P_RUN) || (m_ph == P_SW) || (m_ph == P_FORCE);
    endfunction

    task automatic check_outputs();
        bit sw;
        sw = (m_ph == P_SW) || (m_ph == P_FORCE);
        chk("busy",    32'(o_busy),          32'(m_ph != P_IDLE));
        chk("clear",   32'(o_clear),         32'(m_ph == P_CLEAR || m_ph == P_ABORT));
        chk("done",    32'(o_done),          32'(m_ph == P_DONE));
        chk("cs_en",   32'(o_cswitch_en),    32'(sw));
        chk("cs_force",32'(o_cswitch_force), 32'(m_ph == P_FORCE && m_first));
        chk("stall",   32'(o_stall_req),
            32'(m_active() && ((m_pend > 0 && !i_out_ready) || m_pend == PEND_MAX)));
        chk("swapped", 32'(o_ctx_swapped),   32'(sw && i_cswitch_done && !i_abort));
        chk("ctx_cnt", 32'(o_ctx_cnt),       32'(m_cnt));
        chk("err",     32'(o_err),           32'(m_err));
    endtask

    task automatic model_step();
        bit fin;
        int np;
        if (i_abort && m_ph != P_IDLE) begin
            m_ph = P_ABORT; m_first = 0;
            return;
        end
        fin = i_cswitch_done && (m_ph == P_SW || m_ph == P_FORCE);
        np  = m_pend + ((i_cdone && m_active()) ? 1 : 0) - ((fin && m_ph == P_SW) ? 1 : 0);
        if (np > PEND_MAX) begin
            np = PEND_MAX; m_err = 1;
        end
        m_first = 0;
        case (m_ph)
            P_IDLE:  if (i_start) m_ph = (i_ncontexts == 0) ? P_DONE : P_CLEAR;
            P_CLEAR: begin
                m_ncx = int'(i_ncontexts); m_cnt = 0; np = 0; m_flush = 0; m_err = 0;
                m_ph = P_RUN;
            end
            P_RUN: begin
                if (i_flush) m_flush = 1;
                if ((m_pend > 0 || i_cdone) && i_out_ready) m_ph = P_SW;
                else if (m_flush && m_pend == 0 && i_out_ready) begin
                    m_ph = P_FORCE; m_first = 1;
                end
            end
            P_SW, P_FORCE: if (fin) begin
                if (m_ph == P_FORCE) m_flush = 0;
                m_cnt++;
                if (m_cnt == m_ncx) begin
                    m_ph = P_DONE;
                    if (np > 0) m_err = 1;
                end else if (np > 0 && i_out_ready) m_ph = P_SW;
                else m_ph = P_RUN;
            end
            default: m_ph = P_IDLE;
        endcase
        m_pend = np;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic tick();
        #1;
        check_outputs();
        ev_clear   += int'(o_clear);
        ev_done    += int'(o_done);
        ev_swapped += int'(o_ctx_swapped);
        ev_stall   += int'(o_stall_req);
        model_step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic quiet();
        i_start = 0; i_cdone = 0; i_cswitch_done = 0; i_flush = 0; i_abort = 0;
    endtask

    task automatic clr_ev();
        ev_clear = 0; ev_done = 0; ev_swapped = 0; ev_stall = 0;
    endtask

    // Lets a run finish with cswitch_done answered promptly; bounded.
    task automatic drain_to_idle(input string name);
        int c;
        for (c = 0; c < 300 && m_ph != P_IDLE; c++) begin
            quiet();
            i_out_ready = 1;
            i_cdone = (m_ph == P_RUN) && (c % 7 == 0);
            i_cswitch_done = (m_ph == P_SW || m_ph == P_FORCE) && (c % 3 == 2);
            tick();
        end
        n_tests++;
        if (m_ph != P_IDLE) begin
            n_fail++;
            $display("FAIL %s: timeout waiting for idle", name);
        end
        quiet();
    endtask

    task automatic do_async_reset();
        #2;
        i_rstn = 0;
        #1;
        model_reset();
        chk("arst_busy", 32'(o_busy), 32'd0);
        chk("arst_cnt",  32'(o_ctx_cnt), 32'd0);
        chk("arst_err",  32'(o_err), 32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rstn = 1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int age, c;
        model_reset();
        clr_ev();
        #3;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_clear", 32'(o_clear), 32'd0);
        chk("rst_cnt", 32'(o_ctx_cnt), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        repeat (2) @(negedge i_clk);
        i_rstn = 1;

        // Three contexts, cdone every 40 cycles, switch completes 12 cycles after enable.
        clr_ev();
        i_ncontexts = 16'd3; i_out_ready = 1; i_start = 1;
        tick();
        i_start = 0;
        age = 0;
        for (c = 0; c < 600 && m_ph != P_IDLE; c++) begin
            age = (m_ph == P_SW || m_ph == P_FORCE) ? age + 1 : 0;
            i_cdone = (c % 40 == 39);
            i_cswitch_done = (age == 13);
            if (age == 13) age = -1000;
            tick();
        end
        quiet();
        chk("t1_idle", 32'(m_ph), P_IDLE);
        chk("t1_clear_cycles", 32'(ev_clear), 32'd1);
        chk("t1_swapped", 32'(ev_swapped), 32'd3);
        chk("t1_done", 32'(ev_done), 32'd1);
        chk("t1_ctx_cnt", 32'(o_ctx_cnt), 32'd3);
        chk("t1_err", 32'(o_err), 32'd0);

        // Drain not ready when cdone arrives, ready 20 cycles later.
        i_ncontexts = 16'd1; i_out_ready = 0; i_start = 1;
        tick(); quiet(); tick();
        i_cdone = 1; tick(); i_cdone = 0;
        clr_ev();
        repeat (20) tick();
        chk("t2_stall_cycles", 32'(ev_stall), 32'd20);
        i_out_ready = 1;
        #1;
        chk("t2_en_same_cycle", 32'(o_cswitch_en), 32'd0);
        chk("t2_stall_released", 32'(o_stall_req), 32'd0);
        tick();
        #1;
        chk("t2_en_next_cycle", 32'(o_cswitch_en), 32'd1);
        drain_to_idle("t2");

        // Pend overflow, then abort in SWITCH.
        clr_ev();
        i_ncontexts = 16'd5; i_out_ready = 0; i_start = 1;
        tick(); quiet(); tick();
        i_cdone = 1; tick(); i_cdone = 0; tick();
        i_cdone = 1; tick(); i_cdone = 0; tick();
        #1;
        chk("t3_err_before", 32'(o_err), 32'd0);
        chk("t3_stall_full", 32'(o_stall_req), 32'd1);
        i_cdone = 1; tick(); i_cdone = 0;
        #1;
        chk("t3_err_after", 32'(o_err), 32'd1);
        chk("t3_stall", 32'(o_stall_req), 32'd1);
        i_out_ready = 1; tick();
        i_abort = 1; tick(); i_abort = 0;
        #1;
        chk("t5_clear", 32'(o_clear), 32'd1);
        tick();
        #1;
        chk("t5_busy", 32'(o_busy), 32'd0);
        chk("t5_no_done", 32'(ev_done), 32'd0);

        // Flush with nothing pending forces a switch.
        i_ncontexts = 16'd2; i_out_ready = 1; i_start = 1;
        tick(); quiet(); tick();
        i_flush = 1; tick(); i_flush = 0;
        #1;
        chk("t4_force", 32'(o_cswitch_force), 32'd1);
        chk("t4_en", 32'(o_cswitch_en), 32'd1);
        tick();
        #1;
        chk("t4_force_off", 32'(o_cswitch_force), 32'd0);
        chk("t4_en_held", 32'(o_cswitch_en), 32'd1);
        i_cswitch_done = 1;
        #1;
        chk("t4_swapped", 32'(o_ctx_swapped), 32'd1);
        tick(); i_cswitch_done = 0;
        chk("t4_cnt", 32'(o_ctx_cnt), 32'd1);
        i_abort = 1; tick(); quiet(); tick();

        // Zero contexts: done straight away, no clear.
        clr_ev();
        i_ncontexts = 16'd0; i_start = 1; tick(); i_start = 0;
        #1;
        chk("t6_done", 32'(o_done), 32'd1);
        chk("t6_no_clear", 32'(o_clear), 32'd0);
        tick();
        chk("t6_idle", 32'(o_busy), 32'd0);
        chk("t6_clear_count", 32'(ev_clear), 32'd0);

        // Random traffic against the model.
        for (int r = 0; r < 20000; r++) begin
            quiet();
            i_out_ready = ($urandom_range(0, 9) < 7);
            i_cdone = ($urandom_range(0, 7) == 0);
            i_flush = ($urandom_range(0, 24) == 0);
            if (m_ph == P_SW || m_ph == P_FORCE) i_cswitch_done = ($urandom_range(0, 3) == 0);
            else i_cswitch_done = ($urandom_range(0, 19) == 0);
            if (m_ph == P_IDLE) begin
                i_ncontexts = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 5));
                i_start = ($urandom_range(0, 2) == 0);
            end
            if (m_active() && !i_cdone && !i_cswitch_done && !i_flush &&
                $urandom_range(0, 149) == 0) i_abort = 1;
            if ((r % 2500) > 1234 && (r % 2500) < 1300 && m_active()) begin
                do_async_reset();
                r += 100;
            end else begin
                tick();
            end
        end
        quiet();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
